dmem_responder: RTL

Responder on the CPU data-memory port: the slave side of the M-stage interface (memwrite, address, writedata, readdata).
Serves a word-addressed data RAM plus a small MMIO window (LED register, timer with compare/interrupt, status/control).
Read data is combinational, so the CPU can register it into its W stage in the same cycle.
Writes commit on the clock edge.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_responder_mmio_timer.sv | 87 ++++++++
 rtl/dmem_responder.sv | 96 +++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO window base,
// register offsets inside the window and control-register bit positions.
package dmem_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1FFF_0000;

    localparam logic [4:0] LED_OFF    = 5'h00;
    localparam logic [4:0] TIMER_OFF  = 5'h04;
    localparam logic [4:0] CMP_OFF    = 5'h08;
    localparam logic [4:0] STATUS_OFF = 5'h0C;
    localparam logic [4:0] CTRL_OFF   = 5'h10;

    localparam int EN_BIT    = 0;
    localparam int IRQEN_BIT = 1;

    // An access is misaligned when either low byte-address bit is set.
    function automatic logic is_misaligned(input logic [1:0] lo);
        return (lo != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_responder_mmio_timer.sv
// Timer block of the MMIO window: free-running TIMER with CMP match,
// sticky STATUS.match (write-1-to-clear, set has priority) and CTRL.
module mmio_timer
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [4:0]  off,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [31:0] timer_q, timer_d;
    logic [31:0] cmp_q, cmp_d;
    logic        status_q, status_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        match_s;

    // Next-state for all timer registers; match uses the pre-increment TIMER.
    always_comb begin
        timer_d  = timer_q;
        cmp_d    = cmp_q;
        status_d = status_q;
        ctrl_d   = ctrl_q;
        match_s  = ctrl_q[EN_BIT] && (timer_q == cmp_q);

        if (wr_en && (off == TIMER_OFF)) begin
            timer_d = wdata;
        end else if (ctrl_q[EN_BIT]) begin
            timer_d = timer_q + 32'd1;
        end else begin
            timer_d = timer_q;
        end

        if (wr_en && (off == CMP_OFF)) begin
            cmp_d = wdata;
        end else begin
            cmp_d = cmp_q;
        end

        if (wr_en && (off == CTRL_OFF)) begin
            ctrl_d = wdata[1:0];
        end else begin
            ctrl_d = ctrl_q;
        end

        // A match in the same cycle as a clear keeps the flag set.
        if (match_s) begin
            status_d = 1'b1;
        end else if (wr_en && (off == STATUS_OFF) && wdata[0]) begin
            status_d = 1'b0;
        end else begin
            status_d = status_q;
        end
    end

    // Timer register state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q  <= 32'h0000_0000;
            cmp_q    <= 32'h0000_0000;
            status_q <= 1'b0;
            ctrl_q   <= 2'b00;
        end else begin
            timer_q  <= timer_d;
            cmp_q    <= cmp_d;
            status_q <= status_d;
            ctrl_q   <= ctrl_d;
        end
    end

    // Read mux for the timer registers; other offsets read zero.
    always_comb begin
        case (off)
            TIMER_OFF:  rdata = timer_q;
            CMP_OFF:    rdata = cmp_q;
            STATUS_OFF: rdata = {31'h0000_0000, status_q};
            CTRL_OFF:   rdata = {30'h0000_0000, ctrl_q};
            default:    rdata = 32'h0000_0000;
        endcase
    end

    assign irq = status_q & ctrl_q[IRQEN_BIT];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory port responder: word RAM, MMIO window (LED + timer block),
// combinational read data and a sticky address-error flag.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_AW    = 10,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
    parameter int          LED_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memwrite,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [LED_W-1:0]  led,
    output logic              irq,
    output logic              addr_err
);

    localparam int RAM_DEPTH = 1 << RAM_AW;

    logic [31:0]      mem_q [RAM_DEPTH];
    logic [LED_W-1:0] led_q, led_d;
    logic             addr_err_q, addr_err_d;
    logic             ram_hit_s, mmio_hit_s, misaligned_s;
    logic             ram_we_s, mmio_we_s;
    logic [31:0]      timer_rdata_s;

    // Address decode and write-enable qualification.
    always_comb begin
        ram_hit_s    = (addr[31:RAM_AW+2] == {(30-RAM_AW){1'b0}});
        mmio_hit_s   = (addr[31:5] == MMIO_BASE[31:5]);
        misaligned_s = is_misaligned(addr[1:0]);
        ram_we_s     = memwrite && ram_hit_s && !misaligned_s;
        mmio_we_s    = memwrite && mmio_hit_s && !misaligned_s;
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_q[addr[RAM_AW+1:2]] <= wdata;
        end
    end

    // Next-state for the LED register and the sticky error flag.
    always_comb begin
        if (mmio_we_s && (addr[4:0] == LED_OFF)) begin
            led_d = wdata[LED_W-1:0];
        end else begin
            led_d = led_q;
        end
        addr_err_d = addr_err_q | misaligned_s | !(ram_hit_s | mmio_hit_s);
    end

    // LED and error-flag registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q      <= {LED_W{1'b0}};
            addr_err_q <= 1'b0;
        end else begin
            led_q      <= led_d;
            addr_err_q <= addr_err_d;
        end
    end

    mmio_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .wr_en (mmio_we_s),
        .off   (addr[4:0]),
        .wdata (wdata),
        .rdata (timer_rdata_s),
        .irq   (irq)
    );

    // Combinational read mux; faulty or unmapped accesses read zero.
    always_comb begin
        if (misaligned_s) begin
            rdata = 32'h0000_0000;
        end else if (ram_hit_s) begin
            rdata = mem_q[addr[RAM_AW+1:2]];
        end else if (mmio_hit_s) begin
            case (addr[4:0])
                LED_OFF: rdata = {{(32-LED_W){1'b0}}, led_q};
                default: rdata = timer_rdata_s;
            endcase
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    assign led      = led_q;
    assign addr_err = addr_err_q;

endmodule
